// File: rtl/rv32m_muldiv.sv
// rv32m_muldiv: iterative RV32M multiply/divide unit beside the execute-stage ALU.
// Latency N+2 edges (N = DATA_WIDTH/BITS_PER_CYCLE), 2 for divide special cases; result held in DONE until out_ready.
module rv32m_muldiv #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_WIDTH      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            func3,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  busy
);
  localparam int W  = DATA_WIDTH;
  localparam int B  = BITS_PER_CYCLE;
  localparam int N  = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST    = CW'(N - 1);
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PREP = 3'd1;
  localparam logic [2:0] CALC = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]    state;
  logic [2:0]    op;
  logic [W-1:0]  a_q;   // multiplicand or divisor magnitude
  logic [W:0]    hi_q;  // product high half or partial remainder
  logic [W-1:0]  lo_q;  // multiplier / dividend bits shifting out, product low / quotient bits shifting in
  logic [CW-1:0] cnt;
  logic          neg_a;
  logic          neg_b;
  logic          special;

  // operand decode, valid while in PREP (lo_q = raw rs1, a_q = raw rs2)
  logic          is_div;
  logic          sgn_a;
  logic          sgn_b;
  logic          ra_neg;
  logic          rb_neg;
  logic [W-1:0]  abs_a;
  logic [W-1:0]  abs_b;
  logic          div_zero;
  logic          div_ovf;
  logic [W-1:0]  spec_res;

  always_comb begin
    is_div   = op[2];
    sgn_a    = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    sgn_b    = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    ra_neg   = sgn_a && lo_q[W-1];
    rb_neg   = sgn_b && a_q[W-1];
    abs_a    = ra_neg ? -lo_q : lo_q;
    abs_b    = rb_neg ? -a_q : a_q;
    div_zero = is_div && (a_q == '0);
    div_ovf  = is_div && !op[0] && (lo_q == MOST_NEG) && (a_q == '1);
    if (div_zero)
      spec_res = op[1] ? lo_q : '1;
    else
      spec_res = op[1] ? '0 : lo_q;
  end

  // one CALC step: B multiplier bits or B quotient bits
  logic [W+B-1:0] mul_add;
  logic [W+B-1:0] mul_sum;
  logic [W:0]     rem_t;
  logic [W-1:0]   quo_t;

  always_comb begin
    mul_add = '0;
    for (int j = 0; j < B; j++) begin
      if (lo_q[j]) mul_add = mul_add + ({{B{1'b0}}, a_q} << j);
    end
    mul_sum = {{B{1'b0}}, hi_q[W-1:0]} + mul_add;
    rem_t   = hi_q;
    quo_t   = lo_q;
    for (int j = 0; j < B; j++) begin
      rem_t = {rem_t[W-1:0], quo_t[W-1]};
      quo_t = {quo_t[W-2:0], 1'b0};
      if (rem_t >= {1'b0, a_q}) begin
        rem_t    = rem_t - {1'b0, a_q};
        quo_t[0] = 1'b1;
      end
    end
  end

  // sign correction and result selection
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   rem_mag;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;
  logic [W-1:0]   fix_res;

  always_comb begin
    prod     = {hi_q[W-1:0], lo_q};
    prod_fix = (neg_a ^ neg_b) ? -prod : prod;
    rem_mag  = hi_q[W-1:0];
    quo_fix  = (neg_a ^ neg_b) ? -lo_q : lo_q;
    rem_fix  = neg_a ? -rem_mag : rem_mag;
    case (op)
      3'd0:             fix_res = prod_fix[W-1:0];
      3'd1, 3'd2, 3'd3: fix_res = prod_fix[2*W-1:W];
      3'd4, 3'd5:       fix_res = quo_fix;
      default:          fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op      <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt     <= '0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      special <= 1'b0;
      rd_data <= '0;
      out_tag <= '0;
    end else if (flush) begin
      state   <= IDLE;
      special <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state   <= PREP;
            op      <= func3;
            lo_q    <= rs1_data;
            a_q     <= rs2_data;
            hi_q    <= '0;
            out_tag <= in_tag;
            special <= 1'b0;
          end
        end
        PREP: begin
          // special results are loaded on the first PREP cycle and presented after the second
          if (special) begin
            state <= DONE;
          end else if (div_zero || div_ovf) begin
            special <= 1'b1;
            rd_data <= spec_res;
          end else begin
            neg_a <= ra_neg;
            neg_b <= rb_neg;
            cnt   <= '0;
            hi_q  <= '0;
            a_q   <= is_div ? abs_b : abs_a;
            lo_q  <= is_div ? abs_a : abs_b;
            state <= CALC;
          end
        end
        CALC: begin
          if (is_div) begin
            hi_q <= rem_t;
            lo_q <= quo_t;
          end else begin
            hi_q <= {1'b0, mul_sum[W+B-1:B]};
            lo_q <= {mul_sum[B-1:0], lo_q[W-1:B]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          rd_data <= fix_res;
          state   <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_rv32m_muldiv.sv
// Directed-vector bench for rv32m_muldiv at radix 1 (u_r1) and radix 4 (u_r4).
module tb_rv32m_muldiv;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid0, in_valid1;
  logic        out_ready;
  logic [2:0]  func3;
  logic [31:0] rs1, rs2;
  logic [4:0]  in_tag;

  logic        in_ready0, out_valid0, busy0;
  logic [31:0] rd_data0;
  logic [4:0]  out_tag0;
  logic        in_ready1, out_valid1, busy1;
  logic [31:0] rd_data1;
  logic [4:0]  out_tag1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv32m_muldiv #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1), .TAG_WIDTH(5)) u_r1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid0), .in_ready(in_ready0),
    .func3(func3), .rs1_data(rs1), .rs2_data(rs2), .in_tag(in_tag),
    .out_valid(out_valid0), .out_ready(out_ready), .rd_data(rd_data0), .out_tag(out_tag0),
    .busy(busy0)
  );

  rv32m_muldiv #(.DATA_WIDTH(32), .BITS_PER_CYCLE(4), .TAG_WIDTH(5)) u_r4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid1), .in_ready(in_ready1),
    .func3(func3), .rs1_data(rs1), .rs2_data(rs2), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(out_ready), .rd_data(rd_data1), .out_tag(out_tag1),
    .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // counts edges after the acceptance edge until out_valid is seen (bounded)
  task automatic wait_valid(input int inst, output int lat);
    lat = 0;
    while (((inst == 0) ? out_valid0 : out_valid1) !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input int inst, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] exp, input int exp_lat, input string name);
    int lat;
    @(negedge clk);
    func3 = f; rs1 = a; rs2 = b; in_tag = tag; out_ready = 1'b1;
    if (inst == 0) in_valid0 = 1'b1; else in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    wait_valid(inst, lat);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check(name, (inst == 0) ? rd_data0 : rd_data1, exp);
    check({name, " tag"}, (inst == 0) ? 32'(out_tag0) : 32'(out_tag1), 32'(tag));
    @(posedge clk); #1;
    check({name, " ready after"}, (inst == 0) ? 32'(in_ready0) : 32'(in_ready1), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    logic [31:0] held_rd;
    logic [4:0]  held_tag;

    rst_n = 1'b0; flush = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0; out_ready = 1'b0;
    func3 = '0; rs1 = '0; rs2 = '0; in_tag = '0;
    #12;
    check("reset in_ready", 32'(in_ready0), 32'd1);
    check("reset busy", 32'(busy0), 32'd0);
    check("reset out_valid", 32'(out_valid0), 32'd0);
    check("reset rd_data", rd_data0, 32'd0);
    check("reset out_tag", 32'(out_tag0), 32'd0);
    check("reset r4 in_ready", 32'(in_ready1), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(0, 3'd0, 32'd7,        32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFEB, 34, "mul");
    do_op(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 34, "mulh");
    do_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 34, "mulhu");
    do_op(0, 3'd2, 32'hFFFF_FFFF, 32'd2,        5'd3,  32'hFFFF_FFFF, 34, "mulhsu");
    do_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2,        5'd4,  32'hFFFF_FFFD, 34, "div");
    do_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2,        5'd5,  32'hFFFF_FFFF, 34, "rem");
    do_op(0, 3'd5, 32'd100,      32'd7,        5'd6,  32'd14,        34, "divu");
    do_op(0, 3'd7, 32'd100,      32'd7,        5'd7,  32'd2,         34, "remu");
    do_op(0, 3'd5, 32'd5,        32'd0,        5'd8,  32'hFFFF_FFFF, 2,  "divu by zero");
    do_op(0, 3'd6, 32'd5,        32'd0,        5'd9,  32'd5,         2,  "rem by zero");
    do_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 2,  "div overflow");
    do_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         2,  "rem overflow");

    // back-pressure: MULHU result held for 10 stalled cycles, next request queued meanwhile
    @(negedge clk);
    func3 = 3'd3; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; in_tag = 5'd17; out_ready = 1'b0;
    in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    wait_valid(0, lat);
    check("stall latency", 32'(lat), 32'd34);
    check("stall result", rd_data0, 32'hFFFF_FFFE);
    held_rd = rd_data0;
    held_tag = out_tag0;
    func3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7; in_tag = 5'd9; in_valid0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall out_valid", 32'(out_valid0), 32'd1);
      check("stall rd_data", rd_data0, held_rd);
      check("stall out_tag", 32'(out_tag0), 32'(held_tag));
      check("stall in_ready", 32'(in_ready0), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("handshake out_valid", 32'(out_valid0), 32'd0);
    check("handshake in_ready", 32'(in_ready0), 32'd1);
    @(posedge clk); #1;
    check("queued accepted", 32'(in_ready0), 32'd0);
    in_valid0 = 1'b0;
    wait_valid(0, lat);
    check("queued latency", 32'(lat), 32'd34);
    check("queued result", rd_data0, 32'd14);
    check("queued tag", 32'(out_tag0), 32'd9);
    @(posedge clk); #1;

    // flush in IDLE blocks acceptance on that edge
    @(negedge clk);
    flush = 1'b1; in_valid0 = 1'b1;
    @(posedge clk); #1;
    check("idle flush no accept", 32'(in_ready0), 32'd1);
    flush = 1'b0; in_valid0 = 1'b0;

    // flush during CALC
    @(negedge clk);
    func3 = 3'd0; rs1 = 32'd7; rs2 = 32'd3; in_tag = 5'd3; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("busy in calc", 32'(busy0), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush in_ready", 32'(in_ready0), 32'd1);
    check("flush busy", 32'(busy0), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid0 === 1'b1) seen++;
    end
    check("flush no out_valid", 32'(seen), 32'd0);

    // asynchronous reset during CALC
    @(negedge clk);
    func3 = 3'd0; rs1 = 32'd7; rs2 = 32'd3; in_tag = 5'd21; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid reset in_ready", 32'(in_ready0), 32'd1);
    check("mid reset busy", 32'(busy0), 32'd0);
    check("mid reset out_valid", 32'(out_valid0), 32'd0);
    check("mid reset rd_data", rd_data0, 32'd0);
    check("mid reset out_tag", 32'(out_tag0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1, 3'd0, 32'd7,        32'hFFFF_FFFD, 5'd4, 32'hFFFF_FFEB, 10, "r4 mul");
    do_op(1, 3'd4, 32'hFFFF_FFF9, 32'd2,        5'd6, 32'hFFFF_FFFD, 10, "r4 div");
    do_op(1, 3'd7, 32'd100,      32'd7,        5'd7, 32'd2,         10, "r4 remu");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
